// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM encoding and operand-class helpers for muldiv_iter
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative RV M-extension unit, one shift-add / restoring-divide bit per cycle
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*XLEN:0]    r_acc;
  logic [XLEN-1:0]    r_opnd;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [2:0]         r_op;
  logic [XLEN-1:0]    r_result;
  logic [TAG_W-1:0]   r_tag;

  logic               w_accept;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_mag_a;
  logic [XLEN-1:0]    w_mag_b;
  logic               w_div0;
  logic               w_ovf;
  logic               w_special;
  logic [XLEN-1:0]    w_special_res;
  logic               w_last;

  logic [XLEN:0]      w_mul_sum;
  logic [2*XLEN:0]    w_mul_next;
  logic [XLEN:0]      w_div_hi;
  logic               w_div_ge;
  logic [XLEN:0]      w_div_diff;
  logic [2*XLEN:0]    w_div_next;

  logic [2*XLEN-1:0]  w_prod_f;
  logic [XLEN-1:0]    w_quo_f;
  logic [XLEN-1:0]    w_rem_f;
  logic [XLEN-1:0]    w_fix;

  assign in_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign out_valid  = (r_state == ST_DONE);
  assign out_result = r_result;
  assign out_tag    = r_tag;

  assign w_accept = in_valid && in_ready && !flush;
  assign w_last   = (r_cnt == CNT_W'(XLEN - 1));

  assign w_a_neg = rs1_signed(in_op) && in_rs1[XLEN-1];
  assign w_b_neg = rs2_signed(in_op) && in_rs2[XLEN-1];
  assign w_mag_a = w_a_neg ? -in_rs1 : in_rs1;
  assign w_mag_b = w_b_neg ? -in_rs2 : in_rs2;

  // Divide corner cases bypass the iteration entirely and finish in one cycle.
  assign w_div0    = is_div(in_op) && (in_rs2 == '0);
  assign w_ovf     = is_div(in_op) && rs2_signed(in_op) &&
                     (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
  assign w_special = w_div0 || w_ovf;

  always_comb begin
    w_special_res = '0;
    if (w_div0) begin
      w_special_res = in_op[1] ? in_rs1 : '1;
    end else if (w_ovf) begin
      w_special_res = in_op[1] ? '0 : in_rs1;
    end
  end

  // Multiply: {carry, hi, lo} where lo shifts the multiplier out and the product in.
  assign w_mul_sum  = r_acc[2*XLEN:XLEN] + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {1'b0, w_mul_sum, r_acc[XLEN-1:1]};

  // Divide: {partial remainder, dividend/quotient}, shift left then trial-subtract.
  assign w_div_hi   = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_ge   = (w_div_hi >= {1'b0, r_opnd});
  assign w_div_diff = w_div_hi - {1'b0, r_opnd};
  assign w_div_next = {(w_div_ge ? w_div_diff : w_div_hi), r_acc[XLEN-2:0], w_div_ge};

  always_comb begin
    w_prod_f = (r_sign_a ^ r_sign_b) ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
    w_quo_f  = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem_f  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    w_fix    = w_rem_f;
    case (r_op)
      OP_MUL:                       w_fix = w_prod_f[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod_f[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix = w_quo_f;
      default:                      w_fix = w_rem_f;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_special ? ST_DONE : ST_CALC;
      ST_CALC:  if (w_last) w_next = ST_FIXUP;
      ST_FIXUP: w_next = ST_DONE;
      ST_DONE:  if (out_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_op     <= '0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (w_accept) begin
      r_op     <= in_op;
      r_tag    <= in_tag;
      r_sign_a <= w_a_neg;
      r_sign_b <= w_b_neg;
      r_cnt    <= '0;
      // r_opnd holds whichever magnitude is not preloaded into the accumulator.
      if (is_div(in_op)) begin
        r_opnd <= w_mag_b;
        r_acc  <= {{(XLEN+1){1'b0}}, w_mag_a};
      end else begin
        r_opnd <= w_mag_a;
        r_acc  <= {{(XLEN+1){1'b0}}, w_mag_b};
      end
      if (w_special) r_result <= w_special_res;
    end else if (!flush && (r_state == ST_CALC)) begin
      r_acc <= is_div(r_op) ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (!flush && (r_state == ST_FIXUP)) begin
      r_result <= w_fix;
    end
  end

endmodule
